core_boot_ctrl: RTL and testbench

//   Boot sequencer for the tiny RISC-V core's program ROM. Holds the core in

---
 rtl/core_boot_ctrl_if.sv | 29 ++
 rtl/core_boot_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_core_boot_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_boot_ctrl_if.sv
// Boot loader bus bundle: pad-side byte stream in, instruction-memory write
// port and core control out. The master modport drives the byte stream and
// the load request. The slave modport is the boot controller.
interface core_boot_ctrl_if #(
    parameter int ADDR_BITS = 4,
    parameter int WORD_BITS = 32
);
    logic                 load_req;
    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 byte_ready;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [WORD_BITS-1:0] mem_wdata;
    logic                 core_run;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output load_req, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, core_run, busy, done, err
    );

    modport slave (
        input  load_req, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, core_run, busy, done, err
    );
endinterface

// File: rtl/core_boot_ctrl.sv
// Boot sequencer for the tiny core's program ROM.
// Holds the core in reset while a little-endian byte stream is assembled
// into words and written to instruction memory, then releases the core.
// Optional feature macro: CORE_BOOT_CHECKSUM_EN. When it is defined, a
// trailing mod-256 checksum byte must match the image sum before release.
module core_boot_ctrl #(
    parameter int ADDR_BITS = 4,
    parameter int WORD_BITS = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               reset,
    core_boot_ctrl_if.slave    bus
);
    localparam int LANES    = WORD_BITS / 8;
    localparam int IDX_BITS = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TMR_BITS = $clog2(TIMEOUT + 1);
    localparam logic [IDX_BITS-1:0]  LAST_IDX  = IDX_BITS'(LANES - 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};
    // Timer holds idle cycles already seen; the TIMEOUT-th idle cycle errors.
    localparam logic [TMR_BITS-1:0]  TMR_LIMIT = TMR_BITS'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
`ifdef CORE_BOOT_CHECKSUM_EN
        ST_CHK   = 3'd3,
`endif
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    state_t               state_q,      state_d;
    logic [ADDR_BITS-1:0] word_ptr_q,   word_ptr_d;
    logic [IDX_BITS-1:0]  byte_idx_q,   byte_idx_d;
    logic [TMR_BITS-1:0]  timer_q,      timer_d;
    logic [WORD_BITS-1:0] shift_q,      shift_d;
`ifdef CORE_BOOT_CHECKSUM_EN
    logic [7:0]           sum_q,        sum_d;
`endif
    logic                 byte_ready_q, byte_ready_d;
    logic                 mem_we_q,     mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q,   mem_addr_d;
    logic [WORD_BITS-1:0] mem_wdata_q,  mem_wdata_d;
    logic                 core_run_q,   core_run_d;
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;
    logic                 err_q,        err_d;

    logic                 transfer_s;
    logic [WORD_BITS-1:0] asm_word_s;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        word_ptr_d  = word_ptr_q;
        byte_idx_d  = byte_idx_q;
        timer_d     = timer_q;
        shift_d     = shift_q;
`ifdef CORE_BOOT_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;

        // A byte only counts when the registered ready was high this cycle.
        transfer_s = bus.byte_valid & byte_ready_q;
        asm_word_s = shift_q;
        asm_word_s[{byte_idx_q, 3'b000} +: 8] = bus.byte_data;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus.load_req) begin
                    state_d    = ST_LOAD;
                    word_ptr_d = {ADDR_BITS{1'b0}};
                    byte_idx_d = {IDX_BITS{1'b0}};
                    timer_d    = {TMR_BITS{1'b0}};
`ifdef CORE_BOOT_CHECKSUM_EN
                    sum_d      = 8'h00;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (!bus.load_req) begin
                    state_d = ST_ERR;
                end else if (transfer_s) begin
                    shift_d = asm_word_s;
                    timer_d = {TMR_BITS{1'b0}};
`ifdef CORE_BOOT_CHECKSUM_EN
                    sum_d   = sum_q + bus.byte_data;
`endif
                    if (byte_idx_q == LAST_IDX) begin
                        byte_idx_d  = {IDX_BITS{1'b0}};
                        mem_addr_d  = word_ptr_q;
                        mem_wdata_d = asm_word_s;
                        state_d     = ST_WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_BITS'(1'b1);
                    end
                end else if (timer_q == TMR_LIMIT) begin
                    state_d = ST_ERR;
                end else begin
                    timer_d = timer_q + TMR_BITS'(1'b1);
                end
            end
            ST_WRITE: begin
                timer_d = {TMR_BITS{1'b0}};
                if (!bus.load_req) begin
                    state_d = ST_ERR;
                end else if (word_ptr_q == LAST_ADDR) begin
`ifdef CORE_BOOT_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_RUN;
                    done_d  = 1'b1;
`endif
                end else begin
                    word_ptr_d = word_ptr_q + ADDR_BITS'(1'b1);
                    state_d    = ST_LOAD;
                end
            end
`ifdef CORE_BOOT_CHECKSUM_EN
            ST_CHK: begin
                if (!bus.load_req) begin
                    state_d = ST_ERR;
                end else if (transfer_s) begin
                    if (bus.byte_data == sum_q) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (timer_q == TMR_LIMIT) begin
                    state_d = ST_ERR;
                end else begin
                    timer_d = timer_q + TMR_BITS'(1'b1);
                end
            end
`endif
            ST_ERR: begin
                if (!bus.load_req) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        mem_we_d   = (state_d == ST_WRITE);
        core_run_d = (state_d == ST_RUN);
        err_d      = (state_d == ST_ERR);
`ifdef CORE_BOOT_CHECKSUM_EN
        byte_ready_d = (state_d == ST_LOAD) || (state_d == ST_CHK);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_WRITE) || (state_d == ST_CHK);
`else
        byte_ready_d = (state_d == ST_LOAD);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_WRITE);
`endif
    end

    // State, datapath and output registers; async reset drops any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            word_ptr_q   <= {ADDR_BITS{1'b0}};
            byte_idx_q   <= {IDX_BITS{1'b0}};
            timer_q      <= {TMR_BITS{1'b0}};
            shift_q      <= {WORD_BITS{1'b0}};
`ifdef CORE_BOOT_CHECKSUM_EN
            sum_q        <= 8'h00;
`endif
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_BITS{1'b0}};
            mem_wdata_q  <= {WORD_BITS{1'b0}};
            core_run_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_ptr_q   <= word_ptr_d;
            byte_idx_q   <= byte_idx_d;
            timer_q      <= timer_d;
            shift_q      <= shift_d;
`ifdef CORE_BOOT_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_run_q   <= core_run_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.core_run   = core_run_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_core_boot_ctrl.sv
// Directed testbench for core_boot_ctrl (ADDR_BITS=4, WORD_BITS=32, TIMEOUT=255).
// A small memory model records every write strobe from the DUT.
module tb_core_boot_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    core_boot_ctrl_if #(.ADDR_BITS(4), .WORD_BITS(32)) bus ();

    core_boot_ctrl #(.ADDR_BITS(4), .WORD_BITS(32), .TIMEOUT(255)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Instruction memory model and write counter.
    logic [31:0] mem [16];
    int          we_count = 0;

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            we_count          <= we_count + 1;
        end
    end

    // Hard stop in case something never terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL send_byte_ready: byte_ready=%b, required 1 within 20 cycles", bus.byte_ready);
        end
        step();
        bus.byte_valid = 1'b0;
    endtask

    // Streams 64 bytes base..base+63 (plus the checksum byte when enabled)
    // and checks the final write strobe.
    task automatic load_image(input logic [7:0] base, input logic [7:0] csum);
        logic [7:0]  b;
        logic [31:0] exp_w;
        for (int i = 0; i < 64; i++) begin
            b = base + 8'(i);
            send_byte(b);
        end
        exp_w = {base + 8'd63, base + 8'd62, base + 8'd61, base + 8'd60};
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 4'd15 || bus.mem_wdata !== exp_w) begin
            errors++;
            $display("FAIL last_write: we=%b addr=%0d data=%h, required we=1 addr=15 data=%h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_w);
        end
`ifdef CORE_BOOT_CHECKSUM_EN
        send_byte(csum);
`else
        b = csum;
`endif
    endtask

    // Waits for the done pulse, drops load_req in RUN, checks the pulse is one cycle.
    task automatic finish_ok();
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        bus.load_req = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.core_run !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: done=%b core_run=%b, required 1 1", bus.done, bus.core_run);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.core_run !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: done=%b core_run=%b busy=%b, required 0 1 0",
                     bus.done, bus.core_run, bus.busy);
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.load_req   = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        step();
        step();
        checks++;
        if ({bus.byte_ready, bus.mem_we, bus.core_run, bus.busy, bus.done, bus.err} !== 6'b000000
            || bus.mem_addr !== 4'd0 || bus.mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/we/run/busy/done/err=%b addr=%0d data=%h, required all 0",
                     {bus.byte_ready, bus.mem_we, bus.core_run, bus.busy, bus.done, bus.err},
                     bus.mem_addr, bus.mem_wdata);
        end
        reset = 1'b0;
        step();
        step();
        checks++;
        if (bus.core_run !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_to_run: core_run=%b done=%b busy=%b, required 1 0 0",
                     bus.core_run, bus.done, bus.busy);
        end
        checks++;
        if (we_count !== 0) begin
            errors++;
            $display("FAIL no_write_after_reset: writes=%0d, required 0", we_count);
        end
    endtask

    task automatic test_full_load();
        int w0;
        w0 = we_count;
        bus.load_req = 1'b1;
        step();
        checks++;
        if (bus.core_run !== 1'b0 || bus.busy !== 1'b1 || bus.byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_entry: core_run=%b busy=%b ready=%b, required 0 1 1",
                     bus.core_run, bus.busy, bus.byte_ready);
        end
        load_image(8'h00, 8'hE0);
        finish_ok();
        checks++;
        if (we_count - w0 !== 16) begin
            errors++;
            $display("FAIL full_load_count: writes=%0d, required 16", we_count - w0);
        end
        checks++;
        if (mem[0] !== 32'h03020100 || mem[5] !== 32'h17161514 || mem[15] !== 32'h3F3E3D3C) begin
            errors++;
            $display("FAIL full_load_data: m0=%h m5=%h m15=%h, required 03020100 17161514 3f3e3d3c",
                     mem[0], mem[5], mem[15]);
        end
    endtask

    task automatic test_reload_in_run();
        int w0;
        w0 = we_count;
        bus.load_req = 1'b1;
        step();
        checks++;
        if (bus.core_run !== 1'b0) begin
            errors++;
            $display("FAIL reload_core_run: core_run=%b, required 0", bus.core_run);
        end
        load_image(8'h40, 8'hE0);
        finish_ok();
        checks++;
        if (we_count - w0 !== 16 || mem[0] !== 32'h43424140 || mem[15] !== 32'h7F7E7D7C) begin
            errors++;
            $display("FAIL reload_data: writes=%0d m0=%h m15=%h, required 16 43424140 7f7e7d7c",
                     we_count - w0, mem[0], mem[15]);
        end
    endtask

    task automatic test_abort();
        int w0;
        w0 = we_count;
        bus.load_req = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            send_byte(8'h80 + 8'(i));
        end
        bus.load_req = 1'b0;
        step();
        checks++;
        if (bus.err !== 1'b1 || bus.core_run !== 1'b0 || bus.busy !== 1'b0
            || bus.byte_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_err: err=%b run=%b busy=%b ready=%b we=%b, required 1 0 0 0 0",
                     bus.err, bus.core_run, bus.busy, bus.byte_ready, bus.mem_we);
        end
        step();
        checks++;
        if (bus.err !== 1'b0 || bus.core_run !== 1'b0) begin
            errors++;
            $display("FAIL abort_exit: err=%b core_run=%b, required 0 0", bus.err, bus.core_run);
        end
        step();
        checks++;
        if (bus.core_run !== 1'b1) begin
            errors++;
            $display("FAIL abort_rerun: core_run=%b, required 1", bus.core_run);
        end
        checks++;
        if (we_count - w0 !== 2 || mem[0] !== 32'h83828180 || mem[1] !== 32'h87868584
            || mem[2] !== 32'h4B4A4948) begin
            errors++;
            $display("FAIL abort_mem: writes=%0d m0=%h m1=%h m2=%h, required 2 83828180 87868584 4b4a4948",
                     we_count - w0, mem[0], mem[1], mem[2]);
        end
    endtask

    task automatic test_timeout();
        bus.load_req = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h10 + 8'(i));
        end
        repeat (254) step();
        checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: err=%b busy=%b after 254 idle cycles, required 0 1",
                     bus.err, bus.busy);
        end
        step();
        checks++;
        if (bus.err !== 1'b1 || bus.core_run !== 1'b0 || bus.byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: err=%b run=%b ready=%b after 255 idle cycles, required 1 0 0",
                     bus.err, bus.core_run, bus.byte_ready);
        end
        repeat (45) step();
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: err=%b with load_req=1, required 1", bus.err);
        end
        bus.load_req = 1'b0;
        step();
        checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b busy=%b, required 0 0", bus.err, bus.busy);
        end
        step();
        checks++;
        if (bus.core_run !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rerun: core_run=%b, required 1", bus.core_run);
        end
    endtask

    task automatic test_async_reset();
        int w0;
        bus.load_req = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hA0 + 8'(i));
        end
        w0 = we_count;
        checks++;
        if (bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_write: mem_we=%b, required 1", bus.mem_we);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.byte_ready, bus.mem_we, bus.core_run, bus.busy, bus.done, bus.err} !== 6'b000000) begin
            errors++;
            $display("FAIL async_reset: rdy/we/run/busy/done/err=%b, required 000000",
                     {bus.byte_ready, bus.mem_we, bus.core_run, bus.busy, bus.done, bus.err});
        end
        step();
        reset        = 1'b0;
        bus.load_req = 1'b0;
        step();
        step();
        checks++;
        if (we_count !== w0 || bus.core_run !== 1'b1) begin
            errors++;
            $display("FAIL reset_drop_write: writes=%0d run=%b, required %0d 1", we_count, bus.core_run, w0);
        end
    endtask

`ifdef CORE_BOOT_CHECKSUM_EN
    task automatic test_checksum();
        bus.load_req = 1'b1;
        step();
        load_image(8'h00, 8'hE0);
        finish_ok();
        bus.load_req = 1'b1;
        step();
        load_image(8'h00, 8'hE1);
        checks++;
        if (bus.err !== 1'b1 || bus.core_run !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL checksum_bad: err=%b run=%b done=%b, required 1 0 0",
                     bus.err, bus.core_run, bus.done);
        end
        bus.load_req = 1'b0;
        step();
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_reload_in_run();
        test_abort();
        test_timeout();
        test_async_reset();
`ifdef CORE_BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
